// File: rtl/sha256_msg_padder.sv
// Byte-serial SHA-256 message padder: packs bytes big-endian into 16-word blocks and
// appends 0x80, zero fill and the 64-bit bit length. Optional macro: SHA256_PAD_LEN_ERR_EN.
//
// state | meaning
// DATA  | accept message bytes from the input stream
// PAD80 | insert the 0x80 terminator byte
// ZERO  | insert 0x00 fill until block index 56
// LEN   | insert the 8 length bytes, MSB first
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sob,
    output logic        out_eob,
    output logic        out_eom,
    output logic        len_err
);

    localparam int CNT_W = LEN_W - 3;

    typedef enum logic [1:0] {DATA, PAD80, ZERO, LEN} state_t;

    state_t           state, state_nxt;
    logic [5:0]       idx;
    logic [5:0]       idx_inc;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [23:0]      asm_reg;
    logic [63:0]      bit_len;
    logic             advance;
    logic             in_fire;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic             cnt_inc;
    logic             msg_done;

    // The byte engine only moves when the output register can take a new word.
    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == DATA) && advance && !rst;
    assign in_fire  = in_valid && in_ready;
    assign idx_inc  = idx + 6'd1;
    assign bit_len  = 64'({byte_cnt, 3'b000});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DATA;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_byte   = 8'h00;
        cnt_inc   = 1'b0;
        msg_done  = 1'b0;
        case (state)
            DATA: begin
                if (in_fire) begin
                    wr_en   = in_keep;
                    wr_byte = in_data;
                    cnt_inc = in_keep;
                    if (in_last) begin
                        state_nxt = PAD80;
                    end
                end
            end
            PAD80: begin
                if (advance) begin
                    wr_en     = 1'b1;
                    wr_byte   = 8'h80;
                    state_nxt = (idx_inc == 6'd56) ? LEN : ZERO;
                end
            end
            ZERO: begin
                if (advance) begin
                    wr_en = 1'b1;
                    if (idx_inc == 6'd56) begin
                        state_nxt = LEN;
                    end
                end
            end
            LEN: begin
                if (advance) begin
                    wr_en = 1'b1;
                    case (idx[2:0])
                        3'd0:    wr_byte = bit_len[63:56];
                        3'd1:    wr_byte = bit_len[55:48];
                        3'd2:    wr_byte = bit_len[47:40];
                        3'd3:    wr_byte = bit_len[39:32];
                        3'd4:    wr_byte = bit_len[31:24];
                        3'd5:    wr_byte = bit_len[23:16];
                        3'd6:    wr_byte = bit_len[15:8];
                        default: wr_byte = bit_len[7:0];
                    endcase
                    if (idx == 6'd63) begin
                        state_nxt = DATA;
                        msg_done  = 1'b1;
                    end
                end
            end
            default: state_nxt = DATA;
        endcase
    end

    // Blocks always start on a word boundary, so the byte lane is the low index bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 6'd0;
            byte_cnt  <= '0;
            asm_reg   <= 24'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_sob   <= 1'b0;
            out_eob   <= 1'b0;
            out_eom   <= 1'b0;
        end else begin
            if (wr_en) begin
                idx <= idx_inc;
                case (idx[1:0])
                    2'd0:    asm_reg[23:16] <= wr_byte;
                    2'd1:    asm_reg[15:8]  <= wr_byte;
                    2'd2:    asm_reg[7:0]   <= wr_byte;
                    default: ;
                endcase
            end
            if (wr_en && (idx[1:0] == 2'd3)) begin
                out_valid <= 1'b1;
                out_data  <= {asm_reg, wr_byte};
                out_sob   <= (idx[5:2] == 4'd0);
                out_eob   <= (idx[5:2] == 4'd15);
                out_eom   <= msg_done;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (msg_done) begin
                byte_cnt <= '0;
            end else if (cnt_inc) begin
                byte_cnt <= cnt_next;
            end
        end
    end

`ifdef SHA256_PAD_LEN_ERR_EN
    logic cnt_full;

    assign cnt_full = &byte_cnt;
    assign cnt_next = cnt_full ? byte_cnt : byte_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            len_err <= 1'b0;
        end else if (cnt_inc && cnt_full) begin
            len_err <= 1'b1;
        end
    end
`else
    assign cnt_next = byte_cnt + CNT_W'(1);
    assign len_err  = 1'b0;
`endif

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Byte-serial SHA-256 message padder that sits between the chip I/O byte interface and the SHA-256 compression core. It accepts message bytes over a valid/ready stream, packs them big-endian into 32-bit words, and appends standard SHA-256 padding: 0x80, zero fill, and a 64-bit big-endian bit length. It emits complete 16-word blocks with block and message framing flags. It generalises the fixed top-level byte loader with a parametrised length-counter width, zero-length message support, and output backpressure.

## Interface
- `LEN_W`, default 64: width of the internal message bit-length counter. Legal range 9..64. Bits of the 64-bit length field above `LEN_W` are emitted as 0.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: an input beat is offered.
- `in_ready` out 1: the padder accepts the beat this cycle.
- `in_data` in 8: message byte.
- `in_keep` in 1: 1 means `in_data` is a message byte. 0 is legal only with `in_last`, and denotes end of message with no byte; this is how an empty message is sent.
- `in_last` in 1: this beat ends the message.
- `out_valid` out 1: `out_data` holds a block word.
- `out_ready` in 1: the consumer takes the word.
- `out_data` out 32: block word, big-endian (first byte in [31:24]).
- `out_sob` out 1: the word is word 0 of a block.
- `out_eob` out 1: the word is word 15 of a block.
- `out_eom` out 1: the word is word 15 of the final block of the message.
- `len_err` out 1: sticky length overflow flag (see Configuration).

## Operation
- FSM states:
  - `DATA`: accepts input bytes.
  - `PAD80`: inserts byte 0x80.
  - `ZERO`: inserts 0x00 bytes.
  - `LEN`: inserts the 8 length bytes, MSB first.
- Byte engine:
  - Advances at most one byte per cycle.
  - A 2-bit byte lane counter fills a 32-bit assembly register.
  - A 6-bit block byte index (0..63) tracks the position in the block.
  - A (`LEN_W`-3)-bit byte counter counts message bytes.
- Engine-advance condition: the output word register is empty, or it is being accepted this cycle (`out_valid && out_ready`).
- `in_ready` = (state == `DATA`) && engine-advance. This is a combinational path from `out_ready`.
- In `DATA`, an accepted beat behaves as follows:
  - With `in_keep`=1, it writes one byte and increments the byte counter.
  - If `in_last` is set, the FSM goes to `PAD80`.
  - A beat with `in_keep`=0 and `in_last`=0 is accepted and ignored.
- `PAD80` writes 0x80, then goes to:
  - `LEN` if the index after the write is 56;
  - `ZERO` otherwise.
- `ZERO` writes 0x00 until the index reaches 56, wrapping through 64 into a fresh block if needed, then goes to `LEN`.
- `LEN` writes the 8 length bytes: {byte_count, 3'b000} zero-extended to 64 bits.
  - After the 8th byte, the FSM returns to `DATA` with the byte counter and index cleared.
  - That word is flagged `out_eom`.
- Whenever the 4th byte lane is written, the assembled word loads the output register and `out_valid` rises.
  - `out_sob` is set when the word's index is 0..3.
  - `out_eob` is set when the index is 60..63.
- Message boundaries:
  - 0..55 data bytes produce 1 block.
  - 56..63 data bytes produce 2 blocks.
  - A message of N bytes produces ceil((N+9)/64) blocks.

## Timing
- Reset values:
  - `in_ready`=0 during reset; it rises combinationally in `DATA` after reset.
  - `out_valid`=0, `out_data`=0, `out_sob`/`out_eob`/`out_eom`=0, `len_err`=0.
  - FSM in `DATA`, all counters 0.
- Latency: `out_valid` is asserted the cycle after the 4th byte of a word is written.
- Throughput: 1 byte per cycle with `out_ready` held high, i.e. one word per 4 cycles.
- Padding cost: the pad bytes take 1 cycle each. There are (N+9) rounded up to a multiple of 64, minus N, pad bytes.
- Output hold rule: while `out_valid` && !`out_ready`, `out_data` and the flags are held stable and the engine stalls. No byte is dropped or duplicated.
- Simultaneous accept and load: on the cycle the output word is accepted, a new word may load and `out_valid` stays high.
- Reset mid-message: a partial word, pending output, and counters are discarded. The next beat starts a new message.

## Configuration
- `SHA256_PAD_LEN_ERR_EN` defined:
  - If an accepted data byte would overflow the byte counter, `len_err` is set and held until `rst`.
  - The counter saturates at its maximum, and the message is still padded.
- Not defined: `len_err` is tied to 0 and the byte counter wraps modulo 2^(`LEN_W`-3).

## Test plan
- "abc" (0x61,0x62,0x63, `in_last` on 0x63) -> word0 0x61626380 with `out_sob`; words 1..14 are 0x00000000; word15 is 0x00000018 with `out_eob` and `out_eom`.
- Empty message (single beat, `in_keep`=0, `in_last`=1) -> 0x80000000, then 14×0x00000000, then 0x00000000 with `out_eom`.
- 56 bytes of 0x00 -> 2 blocks. Block 1 word14 is 0x80000000 and word15 is 0x00000000 with `out_eob` and no `out_eom`. Block 2 words 0..14 are 0, and word15 is 0x000001C0 with `out_eom`.
- "abc" with `out_ready` toggled pseudo-randomly -> the same 16 words in order, `out_data` stable while stalled, no extra `in_ready` pulses while stalled.
- `rst` asserted after 2 bytes of a message, then "abc" sent -> output identical to the first scenario.
- `LEN_W`=9 with `SHA256_PAD_LEN_ERR_EN` defined, 64 data bytes sent -> `len_err` goes to 1 on the 64th byte and stays at 1. Without the macro, `len_err` stays 0 and the length word is 0x00000000.
